// File: rtl/ins_writeback.sv
// Commit stage behind instruction-execute. It captures one execute result, performs an
// optional store over a req/ack handshake with a timeout, then commits the RF write and the PC in one cycle.
module ins_writeback #(
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        op,
  input  logic        reg_w_op,
  input  logic [4:0]  reg_w_reg_idx,
  input  logic [31:0] reg_w_reg_val,
  input  logic        mem_w_op,
  input  logic [31:0] mem_w_mem_addr,
  input  logic [31:0] mem_w_mem_val,
  input  logic        reg_pc_w_op,
  input  logic [31:0] reg_pc_w_val,
  input  logic [31:0] reg_pc_val,
  input  logic        mem_ack,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        pc_we,
  output logic [31:0] pc_wdata,
  output logic        busy,
  output logic        done,
  output logic        wb_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_REQ, COMMIT, ERR} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               cap_reg_w_op;
  logic [4:0]         cap_idx;
  logic [31:0]        cap_reg_val;
  logic [31:0]        cap_mem_addr;
  logic [31:0]        cap_mem_val;
  logic               cap_pc_w_op;
  logic [31:0]        cap_pc_w_val;
  logic [31:0]        cap_pc_val;

  always_comb begin
    // NOTE: defaults first, so every path assigns every variable and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (reg_pc_w_op && (reg_pc_w_val[1:0] != 2'b00)) begin
            state_nxt = ERR;
          end else if (mem_w_op && (mem_w_mem_addr[1:0] != 2'b00)) begin
            state_nxt = ERR;
          end else if (mem_w_op) begin
            state_nxt = MEM_REQ;
            cnt_nxt   = '0;
          end else begin
            state_nxt = COMMIT;
          end
        end
      end
      MEM_REQ: begin
        // An ack on the expiry edge still commits: ack is tested before the timeout.
        if (mem_ack) begin
          state_nxt = COMMIT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_W'(MEM_TIMEOUT)) state_nxt = ERR;
        end
      end
      COMMIT:  state_nxt = IDLE;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_reg_w_op <= 1'b0;
      cap_idx      <= '0;
      cap_reg_val  <= '0;
      cap_mem_addr <= '0;
      cap_mem_val  <= '0;
      cap_pc_w_op  <= 1'b0;
      cap_pc_w_val <= '0;
      cap_pc_val   <= '0;
    end else if (state == IDLE && op) begin
      cap_reg_w_op <= reg_w_op;
      cap_idx      <= reg_w_reg_idx;
      cap_reg_val  <= reg_w_reg_val;
      cap_mem_addr <= mem_w_mem_addr;
      cap_mem_val  <= mem_w_mem_val;
      cap_pc_w_op  <= reg_pc_w_op;
      cap_pc_w_val <= reg_pc_w_val;
      cap_pc_val   <= reg_pc_val;
    end
  end

  // Moore outputs: decoded from state and captured values only.
  always_comb begin
    rf_we     = (state == COMMIT) && cap_reg_w_op && (cap_idx != 5'd0);
    rf_waddr  = rf_we ? cap_idx : 5'd0;
    rf_wdata  = rf_we ? cap_reg_val : 32'd0;
    mem_req   = (state == MEM_REQ);
    mem_addr  = mem_req ? cap_mem_addr : 32'd0;
    mem_wdata = mem_req ? cap_mem_val : 32'd0;
    pc_we     = (state == COMMIT);
    pc_wdata  = 32'd0;
    if (pc_we) pc_wdata = cap_pc_w_op ? cap_pc_w_val : cap_pc_val + PC_STEP;
    done      = (state == COMMIT);
    busy      = (state != IDLE);
    wb_err    = (state == ERR);
  end

endmodule

// File: tb/tb_ins_writeback.sv
// Directed bench for ins_writeback: stimulus pushes expected commits into a scoreboard,
// and a negedge monitor pops and compares them each time done is seen.
module tb_ins_writeback;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        op = 1'b0;
  logic        reg_w_op = 1'b0;
  logic [4:0]  reg_w_reg_idx = '0;
  logic [31:0] reg_w_reg_val = '0;
  logic        mem_w_op = 1'b0;
  logic [31:0] mem_w_mem_addr = '0;
  logic [31:0] mem_w_mem_val = '0;
  logic        reg_pc_w_op = 1'b0;
  logic [31:0] reg_pc_w_val = '0;
  logic [31:0] reg_pc_val = '0;
  logic        mem_ack = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic        busy;
  logic        done;
  logic        wb_err;

  ins_writeback #(.PC_STEP(32'd4), .MEM_TIMEOUT(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .op(op),
    .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
    .mem_w_op(mem_w_op), .mem_w_mem_addr(mem_w_mem_addr), .mem_w_mem_val(mem_w_mem_val),
    .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val), .reg_pc_val(reg_pc_val),
    .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata),
    .busy(busy), .done(done), .wb_err(wb_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge sys_clk) begin
    if (done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: done=1 with no commit expected (pc_wdata=0x%08h)", pc_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata} !== {e.rf_we, e.waddr, e.wdata, 1'b1, e.pc}) begin
          n_err++;
          $display("FAIL commit: got we=%0b idx=%0d data=0x%08h pc_we=%0b pc=0x%08h expected we=%0b idx=%0d data=0x%08h pc_we=1 pc=0x%08h",
                   rf_we, rf_waddr, rf_wdata, pc_we, pc_wdata, e.rf_we, e.waddr, e.wdata, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_commit(input logic we, input logic [4:0] idx, input logic [31:0] data,
                               input logic [31:0] pc);
    exp_t e;
    e.rf_we = we; e.waddr = idx; e.wdata = data; e.pc = pc;
    sb.push_back(e);
  endtask

  // Presents one execute result for a single edge; returns #1 after that edge.
  task automatic issue(input logic rw, input logic [4:0] idx, input logic [31:0] val,
                       input logic mw, input logic [31:0] maddr, input logic [31:0] mval,
                       input logic pw, input logic [31:0] ptgt, input logic [31:0] pcv);
    op = 1'b1;
    reg_w_op = rw; reg_w_reg_idx = idx; reg_w_reg_val = val;
    mem_w_op = mw; mem_w_mem_addr = maddr; mem_w_mem_val = mval;
    reg_pc_w_op = pw; reg_pc_w_val = ptgt; reg_pc_val = pcv;
    step();
    op = 1'b0;
  endtask

  task automatic do_reset();
    #2 sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    check("reset_busy",    {31'd0, busy}, 32'd0);
    check("reset_strobes", {27'd0, rf_we, mem_req, pc_we, done, wb_err}, 32'd0);
    check("reset_data",    rf_wdata | mem_addr | mem_wdata | pc_wdata | {27'd0, rf_waddr}, 32'd0);
    sys_rst_n = 1'b1;
    step();

    // ALU writeback.
    expect_commit(1'b1, 5'd5, 32'h1234_5678, 32'h0000_0104);
    issue(1, 5'd5, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h100);
    check("alu_done", {31'd0, done}, 32'd1);
    step();
    check("alu_idle", {31'd0, busy}, 32'd0);

    // Store, ack sampled on the third edge after the request appears.
    expect_commit(1'b0, 5'd0, 32'd0, 32'h0000_0204);
    issue(0, 0, 0, 1, 32'h2000, 32'hDEAD_BEEF, 0, 0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      check("st_req",   {31'd0, mem_req}, 32'd1);
      check("st_addr",  mem_addr, 32'h2000);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (i == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    check("st_req_drop", {31'd0, mem_req}, 32'd0);
    step();

    // Store plus register write with immediate ack: both commit.
    expect_commit(1'b1, 5'd7, 32'hA5A5_A5A5, 32'h0000_0304);
    issue(1, 5'd7, 32'hA5A5_A5A5, 1, 32'h3000, 32'h1111_2222, 0, 0, 32'h300);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();

    // Branch taken.
    expect_commit(1'b0, 5'd0, 32'd0, 32'h0000_0080);
    issue(0, 0, 0, 0, 0, 0, 1, 32'h80, 32'h400);
    step();

    // x0 write suppressed, PC wraps.
    expect_commit(1'b0, 5'd0, 32'd0, 32'h0000_0000);
    issue(1, 5'd0, 32'h0000_FFFF, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step();

    // Misaligned branch target: sticky error, later ops ignored.
    issue(1, 5'd3, 32'h5, 0, 0, 0, 1, 32'h82, 32'h500);
    check("br_err",   {31'd0, wb_err}, 32'd1);
    check("br_busy",  {31'd0, busy}, 32'd1);
    check("br_no_pc", {31'd0, pc_we}, 32'd0);
    issue(1, 5'd4, 32'h6, 0, 0, 0, 0, 0, 32'h600);
    step();
    check("err_sticky", {31'd0, wb_err}, 32'd1);
    do_reset();
    check("err_cleared", {31'd0, wb_err}, 32'd0);

    // Misaligned store address: error without a request.
    issue(0, 0, 0, 1, 32'h2002, 32'h1, 0, 0, 32'h700);
    check("mis_st_err", {31'd0, wb_err}, 32'd1);
    check("mis_st_req", {31'd0, mem_req}, 32'd0);
    do_reset();

    // Timeout: four cycles of request with no ack, then ERR.
    issue(0, 0, 0, 1, 32'h40, 32'h99, 0, 0, 32'h800);
    for (int i = 0; i < 4; i++) begin
      check("to_req",    {31'd0, mem_req}, 32'd1);
      check("to_no_err", {31'd0, wb_err}, 32'd0);
      step();
    end
    check("to_err",      {31'd0, wb_err}, 32'd1);
    check("to_req_drop", {31'd0, mem_req}, 32'd0);
    do_reset();

    // Ack on the expiry edge wins.
    expect_commit(1'b0, 5'd0, 32'd0, 32'h0000_0904);
    issue(0, 0, 0, 1, 32'h44, 32'h98, 0, 0, 32'h900);
    for (int i = 0; i < 3; i++) step();
    check("late_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("late_no_err", {31'd0, wb_err}, 32'd0);
    check("late_done",   {31'd0, done}, 32'd1);
    step();

    // Reset asserted between edges during a request.
    issue(0, 0, 0, 1, 32'h50, 32'h77, 0, 0, 32'hA00);
    step();
    #2 sys_rst_n = 1'b0;
    #1;
    check("rst_req_drop", {31'd0, mem_req}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    step();
    sys_rst_n = 1'b1;
    step();
    expect_commit(1'b1, 5'd31, 32'hCAFE_F00D, 32'h0000_0B04);
    issue(1, 5'd31, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'hB00);
    step();
    step();

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
